// File: rtl/uart_rx_controller.sv
// UART receive controller: generates the oversample tick, assembles data bits
// reported by the bit detector into bytes (LSB first), buffers good bytes in a
// small FIFO for the host and keeps sticky framing/overrun error flags.
module uart_rx_controller #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_en,
  input  logic [DIV_W-1:0]              baud_div,
  output logic                          sample_tick,
  input  logic                          bd_active_rx,
  input  logic                          bd_bit_ready,
  input  logic                          bd_rx_bit,
  input  logic                          bd_done,
  input  logic                          bd_framing_err,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overrun_err,
  input  logic                          err_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    DISABLED,
    WAIT_IDLE,
    IDLE,
    RECV
  } state_t;

  state_t state, state_next;

  logic [DIV_W-1:0] tick_cnt;
  logic             tick_hit;

  logic             in_recv;
  logic             start_frame;
  logic             take_bit;
  logic             frame_end;
  logic             frame_good;
  logic             frame_bad;

  logic [7:0]       shreg;
  logic [3:0]       bit_cnt;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             pop;
  logic             push;
  logic             overflow;

  // Using >= lets a smaller divisor written mid-count fire at once instead of wrapping
  assign tick_hit    = rst_n && rx_en && (tick_cnt >= baud_div);
  assign sample_tick = tick_hit;

  // Oversample tick counter: held at zero while the receiver is disabled
  always_ff @(posedge clk) begin
    if (!rst_n || !rx_en) begin
      tick_cnt <= '0;
    end else if (tick_hit) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + DIV_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= DISABLED;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: WAIT_IDLE keeps us from joining a frame that is already underway
  always_comb begin
    state_next = state;
    case (state)
      DISABLED:  if (rx_en)         state_next = WAIT_IDLE;
      WAIT_IDLE: if (!bd_active_rx) state_next = IDLE;
      IDLE:      if (bd_active_rx)  state_next = RECV;
      RECV:      if (bd_done)       state_next = IDLE;
      default:                      state_next = DISABLED;
    endcase
    if (!rx_en) begin
      state_next = DISABLED;
    end
  end

  // FSM outputs: busy flag and the frame-start strobe that clears the assembler
  always_comb begin
    in_recv     = (state == RECV);
    rx_busy     = (state == RECV);
    start_frame = (state == IDLE) && (state_next == RECV);
  end

  assign take_bit   = in_recv && bd_bit_ready;
  assign frame_end  = in_recv && bd_done;
  assign frame_good = frame_end && (bit_cnt == 4'd8) && !bd_framing_err;
  assign frame_bad  = frame_end && !frame_good;

  // Byte assembly: shift right so the first received bit ends up in bit 0
  always_ff @(posedge clk) begin
    if (!rst_n || start_frame) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (take_bit) begin
      shreg <= {bd_rx_bit, shreg[7:1]};
      if (bit_cnt != 4'd8) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
  assign rx_valid  = (count != '0);
  assign rx_data   = mem[rd_ptr];
  assign fifo_count = count;
  assign pop       = rx_valid && rx_ready;
  assign push      = frame_good && (!fifo_full || pop);
  assign overflow  = frame_good && fifo_full && !pop;

  // Receive FIFO: a pop in the same cycle frees room for a push into a full FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: a new event in the clear cycle wins over the clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_bad | (frame_err & ~err_clr);
      overrun_err <= overflow  | (overrun_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Testbench for uart_rx_controller: directed and randomized frames, with a
// byte scoreboard checked by an independent monitor on every host pop.
module tb_uart_rx_controller;

  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             rx_en;
  logic [DIV_W-1:0] baud_div;
  logic             sample_tick;
  logic             bd_active_rx;
  logic             bd_bit_ready;
  logic             bd_rx_bit;
  logic             bd_done;
  logic             bd_framing_err;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [CNT_W-1:0] fifo_count;
  logic             rx_busy;
  logic             frame_err;
  logic             overrun_err;
  logic             err_clr;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  bit         exp_frame_err;
  bit         exp_overrun;
  int         ready_mode;
  int         ref_cnt;

  uart_rx_controller #(
    .DIV_W      (DIV_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_en          (rx_en),
    .baud_div       (baud_div),
    .sample_tick    (sample_tick),
    .bd_active_rx   (bd_active_rx),
    .bd_bit_ready   (bd_bit_ready),
    .bd_rx_bit      (bd_rx_bit),
    .bd_done        (bd_done),
    .bd_framing_err (bd_framing_err),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .fifo_count     (fifo_count),
    .rx_busy        (rx_busy),
    .frame_err      (frame_err),
    .overrun_err    (overrun_err),
    .err_clr        (err_clr)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case anything stalls
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every host pop must deliver the oldest byte in the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rx_valid === 1'b1 && rx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pop: actual=0x%0h expected=no byte", rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("rx_data_pop", {24'd0, rx_data}, {24'd0, mon_exp});
      end
    end
  end

  // Advance to just after the next rising edge, dropping all one-cycle pulses
  task automatic next_cycle();
    @(posedge clk);
    #2;
    bd_bit_ready   = 1'b0;
    bd_done        = 1'b0;
    bd_framing_err = 1'b0;
    err_clr        = 1'b0;
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'($urandom_range(0, 1));
      default: rx_ready = 1'b1;
    endcase
  endtask

  // Compare occupancy, head and flags against the model (no pop this cycle)
  task automatic check_status();
    rx_ready = 1'b0;
    @(negedge clk);
    check_output("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
    check_output("rx_valid", 32'(rx_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_output("rx_data_head", {24'd0, rx_data}, {24'd0, exp_q[0]});
    end
    check_output("frame_err", 32'(frame_err), 32'(exp_frame_err));
    check_output("overrun_err", 32'(overrun_err), 32'(exp_overrun));
    check_output("rx_busy_idle", 32'(rx_busy), 32'd0);
  endtask

  task automatic apply_clear();
    next_cycle();
    err_clr       = 1'b1;
    exp_frame_err = 1'b0;
    exp_overrun   = 1'b0;
    next_cycle();
  endtask

  // Tick reference: fires when the cycles elapsed since the last tick reach the divisor
  task automatic run_tick_segment(input bit en, input int div, input int cycles);
    bit exp_tick;
    rx_en    = en;
    baud_div = DIV_W'(div);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      exp_tick = en && (ref_cnt >= div);
      check_output("sample_tick", 32'(sample_tick), 32'(exp_tick));
      if (!en || exp_tick) ref_cnt = 0;
      else                 ref_cnt = ref_cnt + 1;
      next_cycle();
    end
  endtask

  // One frame from the bit detector; the expected outcome goes to the scoreboard
  task automatic apply_stimulus(input logic [8:0] bits, input int nbits, input bit ferr,
                                input bit clr, input int ready_on_done, input bit gaps);
    logic [7:0] exp_byte;
    bit         will_pop;
    next_cycle();
    bd_active_rx = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) next_cycle();
      next_cycle();
      bd_bit_ready = 1'b1;
      bd_rx_bit    = bits[i];
      if (i == 0) begin
        @(negedge clk);
        check_output("rx_busy_frame", 32'(rx_busy), 32'd1);
      end
    end
    if (gaps) repeat ($urandom_range(0, 2)) next_cycle();
    next_cycle();
    bd_done        = 1'b1;
    bd_framing_err = ferr;
    err_clr        = clr;
    if (ready_on_done >= 0) rx_ready = (ready_on_done != 0);
    will_pop = rx_ready && (exp_q.size() != 0);
    if (clr) begin
      exp_frame_err = 1'b0;
      exp_overrun   = 1'b0;
    end
    if (nbits >= 8 && !ferr) begin
      for (int j = 0; j < 8; j++) exp_byte[j] = bits[nbits - 8 + j];
      if (exp_q.size() < FIFO_DEPTH || will_pop) exp_q.push_back(exp_byte);
      else                                        exp_overrun = 1'b1;
    end else begin
      exp_frame_err = 1'b1;
    end
    next_cycle();
    bd_active_rx = 1'b0;
  endtask

  task automatic drain();
    ready_mode = 2;
    repeat (FIFO_DEPTH + 3) next_cycle();
    ready_mode = 0;
  endtask

  initial begin
    logic [8:0] rb;
    int         nb;
    rst_n = 1'b0; rx_en = 1'b0; baud_div = '0;
    bd_active_rx = 1'b0; bd_bit_ready = 1'b0; bd_rx_bit = 1'b0;
    bd_done = 1'b0; bd_framing_err = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    ready_mode = 0; ref_cnt = 0; exp_frame_err = 1'b0; exp_overrun = 1'b0;

    @(posedge clk);
    @(posedge clk);
    #2;
    @(negedge clk);
    check_output("reset_sample_tick", 32'(sample_tick), 32'd0);
    check_output("reset_rx_valid", 32'(rx_valid), 32'd0);
    check_output("reset_fifo_count", 32'(fifo_count), 32'd0);
    check_output("reset_rx_busy", 32'(rx_busy), 32'd0);
    check_output("reset_frame_err", 32'(frame_err), 32'd0);
    check_output("reset_overrun_err", 32'(overrun_err), 32'd0);
    check_output("reset_rx_data", {24'd0, rx_data}, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    $display("[TB] tick generator");
    run_tick_segment(1, 3, 12);
    run_tick_segment(0, 3, 4);
    run_tick_segment(1, 3, 8);
    run_tick_segment(1, 0, 5);
    run_tick_segment(1, 7, 5);
    run_tick_segment(1, 2, 7);
    for (int k = 0; k < 4; k++) begin
      run_tick_segment($urandom_range(0, 3) != 0, $urandom_range(0, 6), $urandom_range(3, 15));
    end
    run_tick_segment(1, 1, 4);
    next_cycle();
    next_cycle();

    $display("[TB] single byte 0xA5");
    apply_stimulus(9'h0A5, 8, 0, 0, -1, 0);
    check_status();
    ready_mode = 2;
    next_cycle();
    ready_mode = 0;
    next_cycle();
    check_status();

    $display("[TB] framing errors");
    apply_stimulus(9'h05A, 8, 1, 0, -1, 1);
    check_status();
    apply_stimulus(9'h0C3, 8, 1, 1, -1, 0);
    check_status();
    apply_clear();
    check_status();
    apply_stimulus(9'h07F, 7, 0, 0, -1, 0);
    check_status();
    apply_clear();

    $display("[TB] overrun");
    for (int b = 1; b <= 5; b++) apply_stimulus(9'(b), 8, 0, 0, -1, 1);
    check_status();
    drain();
    check_status();
    apply_clear();
    check_status();
    for (int b = 1; b <= 4; b++) apply_stimulus(9'(b), 8, 0, 0, -1, 0);
    apply_stimulus(9'd5, 8, 0, 0, 1, 0);
    check_status();
    drain();
    check_status();

    $display("[TB] disable mid-frame and rejoin");
    next_cycle();
    bd_active_rx = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bd_bit_ready = 1'b1;
      bd_rx_bit    = 1'($urandom_range(0, 1));
    end
    next_cycle();
    rx_en = 1'b0;
    next_cycle();
    next_cycle();
    rx_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      bd_bit_ready   = (i < 8);
      bd_rx_bit      = 1'($urandom_range(0, 1));
      bd_done        = (i >= 8);
      bd_framing_err = (i == 9);
      @(negedge clk);
      check_output("rx_busy_wait_idle", 32'(rx_busy), 32'd0);
    end
    next_cycle();
    bd_active_rx = 1'b0;
    next_cycle();
    check_status();
    apply_stimulus(9'h03C, 8, 0, 0, -1, 1);
    check_status();
    drain();

    $display("[TB] reset mid-frame");
    apply_stimulus(9'h011, 7, 0, 0, -1, 0);
    apply_stimulus(9'h022, 8, 0, 0, -1, 0);
    apply_stimulus(9'h033, 8, 0, 0, -1, 0);
    next_cycle();
    bd_active_rx = 1'b1;
    next_cycle();
    bd_bit_ready = 1'b1;
    bd_rx_bit    = 1'b1;
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n        = 1'b1;
    bd_active_rx = 1'b0;
    exp_q.delete();
    exp_frame_err = 1'b0;
    exp_overrun   = 1'b0;
    check_status();
    next_cycle();
    next_cycle();

    $display("[TB] randomized frames");
    for (int k = 0; k < 40; k++) begin
      ready_mode = $urandom_range(0, 1);
      rb = 9'($urandom);
      case ($urandom_range(0, 5))
        0:       nb = 7;
        5:       nb = 9;
        default: nb = 8;
      endcase
      apply_stimulus(rb, nb, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, -1, 1);
      if (k % 5 == 4) check_status();
    end
    drain();
    check_status();
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
Sequences the UART receive datapath. It generates the 16x oversample tick that paces the bit detector from a programmable divisor. It assembles the detector's per-bit outputs into bytes, LSB first, and buffers completed bytes in a small FIFO with a valid/ready interface to the host. It also tracks framing and overrun errors as sticky flags.

Parameters:
DIV_W, 16, width of the baud divisor and of the tick counter.
FIFO_DEPTH, 4, receive FIFO entries; power of two and at least 2.

Ports:
clk  input  1  peripheral clock
rst_n  input  1  synchronous reset, active-low
rx_en  input  1  receiver enable
baud_div  input  DIV_W  tick period minus 1, in clk cycles
sample_tick  output  1  one-cycle oversample tick to the bit detector
bd_active_rx  input  1  bit detector is inside a frame
bd_bit_ready  input  1  one-cycle pulse: bd_rx_bit holds a data bit
bd_rx_bit  input  1  sampled data bit
bd_done  input  1  one-cycle pulse: stop bit evaluated
bd_framing_err  input  1  stop bit was low; qualified by bd_done
rx_data  output  8  head-of-FIFO byte
rx_valid  output  1  FIFO not empty
rx_ready  input  1  host accepts rx_data
fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy
rx_busy  output  1  frame assembly in progress
frame_err  output  1  sticky framing error
overrun_err  output  1  sticky overrun
err_clr  input  1  clears both sticky flags

Behaviour:
- Reset: all outputs 0, FIFO empty, tick counter 0, shift register 0, bit count 0, FSM in DISABLED.
- Tick generator:
  - Counter runs only while rx_en=1.
  - When counter >= baud_div, sample_tick=1 for that cycle and the counter reloads to 0; otherwise the counter increments.
  - baud_div=0 gives a tick every cycle. Using >= means a decrease of baud_div mid-count never stalls.
  - While rx_en=0, counter is held at 0 and sample_tick=0.
- FSM states:
  - DISABLED: go to WAIT_IDLE when rx_en=1.
  - WAIT_IDLE: go to IDLE when bd_active_rx=0. This prevents joining a frame midway.
  - IDLE: go to RECV when bd_active_rx=1. Clear shift register and bit count on entry to RECV.
  - RECV: go to IDLE on bd_done.
  - From any state, rx_en=0 goes to DISABLED next cycle. The partial byte is discarded; FIFO contents and flags are kept.
- rx_busy=1 only in RECV.
- Assembly, RECV only:
  - On bd_bit_ready: shreg <= {bd_rx_bit, shreg[7:1]}; bit count +1, saturating at 8.
  - bd_bit_ready outside RECV is ignored.
- Commit on bd_done in RECV:
  - Good frame: bit count==8 and bd_framing_err=0. Push shreg into the FIFO.
  - Otherwise (bit count!=8 or bd_framing_err=1): set frame_err and discard the byte.
  - bd_done outside RECV is ignored.
- FIFO:
  - rx_data shows the head entry combinationally; it is undefined when rx_valid=0.
  - Pop when rx_valid & rx_ready.
  - A pushed byte appears on rx_valid/rx_data the cycle after bd_done.
  - Push when full without a simultaneous pop: drop the byte, set overrun_err, contents unchanged.
  - Push when full with a simultaneous pop: accepted; count stays FIFO_DEPTH and no overrun.
  - Push and pop together at any occupancy: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags:
  - err_clr clears both flags.
  - If a new error event occurs in the same cycle as err_clr, that flag is 1 afterwards (set wins).
- Reset mid-frame or mid-handshake returns everything to reset values in the next cycle.

Test Plan:
- baud_div=3, rx_en=1 -> sample_tick pulses every 4 clk; rx_en=0 -> tick stops, counter 0; baud_div=0 -> tick every cycle.
- RECV with bits 1,0,1,0,0,1,0,1 LSB first, then bd_done with bd_framing_err=0 -> rx_data=0xA5, rx_valid=1 one cycle after bd_done, fifo_count=1; rx_ready=1 -> rx_valid=0.
- bd_done with bd_framing_err=1 after 8 bits -> no push, frame_err=1. err_clr asserted in the same cycle as a second framing error -> frame_err stays 1.
- Receive 5 bytes 0x01..0x05 with FIFO_DEPTH=4, rx_ready=0 -> count=4, overrun_err=1, reads return 0x01..0x04. Repeat with rx_ready=1 on the 5th push cycle -> no overrun, and 0x05 is retained.
- rx_en 1->0 after 3 bits, then rx_en 1 while bd_active_rx=1 -> controller holds WAIT_IDLE, and the following bd_bit_ready/bd_done pulses push nothing. Once bd_active_rx=0, the next clean frame 0x3C is received correctly.
- Only 7 bits before bd_done -> frame_err=1, no push.
